// File: rtl/aoi_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module  : aoi_sweep_controller
// Purpose : Self-test sequencer that sweeps a four-input AOI gate through all
//           16 input vectors and checks e/f/g against the golden function.
// Rev     : 1.0  initial release
// ============================================================================
module aoi_sweep_controller #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] fail_mask
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       c_LAST_VEC  = 4'hF;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [3:0]       r_vec;
    logic [3:0]       w_vec_next;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_next;
    logic [4:0]       r_err;
    logic [4:0]       w_err_next;
    logic [15:0]      r_mask;
    logic [15:0]      w_mask_next;
    logic [3:0]       r_abcd;
    logic [3:0]       w_abcd_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_done;
    logic             w_done_next;

    logic             w_launch;
    logic             w_exp_e;
    logic             w_exp_f;
    logic             w_exp_g;
    logic             w_fail;

    assign w_launch = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    // Golden model evaluated on the vector currently driven onto the gate
    assign w_exp_e = r_vec[3] & r_vec[2];
    assign w_exp_f = r_vec[1] & r_vec[0];
    assign w_exp_g = ~(w_exp_e | w_exp_f);
    assign w_fail  = (e != w_exp_e) || (f != w_exp_f) || (g != w_exp_g);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_DRIVE;
            c_DRIVE: if (r_hold == c_HOLD_LAST) w_state_next = c_CHECK;
            c_CHECK: w_state_next = (r_vec == c_LAST_VEC) ? c_DONE : c_DRIVE;
            c_DONE:  if (start) w_state_next = c_DRIVE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Gate inputs and status flags are computed for the upcoming state so the
    // registered copies line up with r_state on every cycle.
    always_comb begin
        w_abcd_next = 4'h0;
        w_busy_next = 1'b0;
        w_done_next = 1'b0;
        case (w_state_next)
            c_DRIVE, c_CHECK: begin
                w_abcd_next = w_vec_next;
                w_busy_next = 1'b1;
            end
            c_DONE: begin
                w_abcd_next = 4'hF;
                w_done_next = 1'b1;
            end
            default: begin
                w_abcd_next = 4'h0;
            end
        endcase
    end

    always_comb begin
        w_vec_next  = r_vec;
        w_hold_next = '0;
        w_err_next  = r_err;
        w_mask_next = r_mask;
        if (w_launch) begin
            w_vec_next  = 4'h0;
            w_err_next  = 5'd0;
            w_mask_next = 16'h0000;
        end else if (r_state == c_DRIVE) begin
            w_hold_next = r_hold + 1'b1;
        end else if (r_state == c_CHECK) begin
            if (r_vec != c_LAST_VEC) begin
                w_vec_next = r_vec + 4'd1;
            end
            if (w_fail) begin
                w_err_next  = r_err + 5'd1;
                w_mask_next = r_mask | (16'h0001 << r_vec);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec  <= 4'h0;
            r_hold <= '0;
            r_err  <= 5'd0;
            r_mask <= 16'h0000;
            r_abcd <= 4'h0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_vec  <= w_vec_next;
            r_hold <= w_hold_next;
            r_err  <= w_err_next;
            r_mask <= w_mask_next;
            r_abcd <= w_abcd_next;
            r_busy <= w_busy_next;
            r_done <= w_done_next;
        end
    end

    assign {a, b, c, d} = r_abcd;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_done && (r_err == 5'd0);
    assign err_count    = r_err;
    assign fail_mask    = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_aoi_sweep_controller.sv
`default_nettype none
// Bench for aoi_sweep_controller: two instances (settle 2 and settle 1) with
// behavioural gate models, a vector-order queue and a result scoreboard.
module tb_aoi_sweep_controller;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic sel;
    int   mode;
    int   lag;

    logic a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0;
    logic [4:0]  err0;
    logic [15:0] mask0;
    logic a1, b1, c1, d1, e1, f1, g1, busy1, done1, pass1;
    logic [4:0]  err1;
    logic [15:0] mask1;

    logic start0, start1;
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    aoi_sweep_controller #(.HOLD_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .fail_mask(mask0)
    );

    aoi_sweep_controller #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_mask(mask1)
    );

    function automatic logic [2:0] aoi(input logic [3:0] v);
        logic ee, ff;
        ee = v[3] & v[2];
        ff = v[1] & v[0];
        return {ee, ff, ~(ee | ff)};
    endfunction

    // Gate model for the settle-2 instance: correct, g stuck-at-0, e inverted
    always_comb begin
        {e0, f0, g0} = aoi({a0, b0, c0, d0});
        if (mode == 1) g0 = 1'b0;
        if (mode == 2) e0 = ~e0;
    end

    // Gate model for the settle-1 instance: outputs lag inputs by 1 or 2 cycles
    logic [2:0] p1, p2;
    always @(posedge clk) begin
        p1 <= aoi({a1, b1, c1, d1});
        p2 <= p1;
    end
    assign {e1, f1, g1} = (lag == 1) ? p1 : p2;

    logic [3:0]  m_abcd;
    logic        m_busy, m_done, m_pass;
    logic [4:0]  m_err;
    logic [15:0] m_mask;
    assign m_abcd = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_err  = sel ? err1  : err0;
    assign m_mask = sel ? mask1 : mask0;

    typedef struct {
        int          cyc;
        logic [4:0]  err;
        logic [15:0] mask;
        logic        pss;
    } res_t;

    res_t       rq[$];
    logic [3:0] vq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input int hold, input logic [4:0] e_err, input logic [15:0] e_mask,
                         input int inject_vec, input int abort_cyc);
        res_t       r;
        logic [3:0] prev;
        int         dwell;
        bit         injected;
        bit         fin;
        for (int v = 0; v < 16; v++) vq.push_back(4'(v));
        r.cyc  = 1 + 16 * (hold + 1);
        r.err  = e_err;
        r.mask = e_mask;
        r.pss  = (e_err == 5'd0);
        rq.push_back(r);
        prev     = 4'h0;
        dwell    = 0;
        injected = 0;
        fin      = 0;
        start    = 1'b1;
        for (int k = 1; k <= 300 && !fin; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                chk("busy_after_start", 32'(m_busy), 32'd1);
                chk("done_cleared", 32'(m_done), 32'd0);
            end
            if (abort_cyc == k) begin
                chk("abort_vec", 32'(m_abcd), 32'd7);
                reset = 1'b1;
            end else if (abort_cyc == k - 1) begin
                chk("rst_busy", 32'(m_busy), 32'd0);
                chk("rst_abcd", 32'(m_abcd), 32'd0);
                chk("rst_err", 32'(m_err), 32'd0);
                chk("rst_mask", 32'(m_mask), 32'd0);
                chk("rst_done", 32'(m_done), 32'd0);
                reset = 1'b0;
                vq.delete();
                rq.delete();
                fin = 1;
            end else if (m_busy) begin
                if (dwell == 0 || m_abcd != prev) begin
                    if (dwell != 0) chk("dwell", 32'(dwell), 32'(hold + 1));
                    if (vq.size() == 0) chk("extra_vec", 32'd1, 32'd0);
                    else chk("vec_order", 32'(m_abcd), 32'(vq.pop_front()));
                    prev  = m_abcd;
                    dwell = 1;
                end else begin
                    dwell++;
                end
                if (inject_vec == int'(m_abcd) && !injected) begin
                    start    = 1'b1;
                    injected = 1;
                end
            end else if (m_done) begin
                chk("final_dwell", 32'(dwell), 32'(hold + 1));
                r = rq.pop_front();
                chk("done_cycle", 32'(k), 32'(r.cyc));
                chk("err_count", 32'(m_err), 32'(r.err));
                chk("fail_mask", 32'(m_mask), 32'(r.mask));
                chk("pass", 32'(m_pass), 32'(r.pss));
                chk("done_abcd", 32'(m_abcd), 32'hF);
                chk("vec_left", 32'(vq.size()), 32'd0);
                fin = 1;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
        vq.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] lmask;
        logic [4:0]  lerr;
        logic [3:0]  pv;
        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        mode  = 0;
        lag   = 1;
        repeat (3) @(negedge clk);
        chk("reset_abcd0", 32'({a0, b0, c0, d0}), 32'd0);
        chk("reset_busy0", 32'(busy0), 32'd0);
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_pass0", 32'(pass0), 32'd0);
        chk("reset_err0", 32'(err0), 32'd0);
        chk("reset_mask0", 32'(mask0), 32'd0);
        chk("reset_abcd1", 32'({a1, b1, c1, d1}), 32'd0);
        chk("reset_busy1", 32'(busy1), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_start_while_idle_off", 32'(busy0), 32'd0);

        mode = 0; sweep(2, 5'd0, 16'h0000, -1, -1);
        mode = 1; sweep(2, 5'd9, 16'h0777, -1, -1);
        mode = 2; sweep(2, 5'd16, 16'hFFFF, -1, -1);
        mode = 0; sweep(2, 5'd0, 16'h0000, 5, -1);
        mode = 1; sweep(2, 5'd0, 16'h0000, -1, 24);
        mode = 0; sweep(2, 5'd0, 16'h0000, -1, -1);

        sel = 1'b1;
        lag = 1; sweep(1, 5'd0, 16'h0000, -1, -1);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lag   = 2;
        lmask = 16'h0000;
        lerr  = 5'd0;
        for (int v = 0; v < 16; v++) begin
            pv = (v == 0) ? 4'd0 : 4'(v - 1);
            if (aoi(pv) != aoi(4'(v))) begin
                lmask[v] = 1'b1;
                lerr     = lerr + 5'd1;
            end
        end
        sweep(1, lerr, lmask, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
